// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the core LSU and the data memory.
// Master drives requests; slave returns one-cycle response pulses.
interface data_mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Handshaked RV32 data memory with sub-word access, byte lanes and
// programmable wait states; bad accesses respond with err, no side effects.
module data_mem_lsu #(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    data_mem_lsu_if.slave bus
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [MEM_DEPTH];

    logic          is_b, is_h, is_w;
    logic          bad_f3, misal, oor, err;
    logic [AW-1:0] idx;
    logic [4:0]    sh;
    logic [31:0]   rword, ldata, wsh;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic [3:0]    be;
    logic          access, wr_en;

    always_comb begin
        is_b   = (f3_q == 3'b000) || (f3_q == 3'b100);
        is_h   = (f3_q == 3'b001) || (f3_q == 3'b101);
        is_w   = (f3_q == 3'b010);
        // unsigned variants only exist for loads
        bad_f3 = !(is_b || is_h || is_w) || (we_q && f3_q[2]);
        misal  = (is_h && addr_q[0]) || (is_w && (addr_q[1:0] != 2'b00));
        oor    = {2'b00, addr_q[31:2]} >= 32'(MEM_DEPTH);
        err    = bad_f3 || misal || oor;
        idx    = addr_q[AW+1:2];
        sh     = {addr_q[1:0], 3'b000};
        rword  = mem[idx];
        bsel   = 8'(rword >> sh);
        hsel   = addr_q[1] ? rword[31:16] : rword[15:0];
        ldata  = rword;
        be     = 4'b1111;
        unique case (1'b1)
            is_b: begin
                ldata = f3_q[2] ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
                be    = 4'b0001 << addr_q[1:0];
            end
            is_h: begin
                ldata = f3_q[2] ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                ldata = rword;
                be    = 4'b1111;
            end
        endcase
        wsh    = wdata_q << sh;
        access = (state_q == WAIT) && (cnt_q == 4'd0);
        wr_en  = access && we_q && !err;
    end

    // RAM has no reset; writes are gated by the state register so an
    // asynchronous abort drops a pending store.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rdata_q     <= (we_q || err) ? 32'h0 : ldata;
                        err_q       <= err;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed and randomized checks of data_mem_lsu against a byte-level
// reference model; a second instance covers the multi-cycle latency.
module tb_data_mem_lsu;
    localparam int DEPTH = 1024;
    localparam int LAT1  = 1;
    localparam int LAT4  = 4;

    logic clk;
    logic rst1_n;
    logic rst4_n;

    data_mem_lsu_if bus1 ();
    data_mem_lsu_if bus4 ();

    data_mem_lsu #(.MEM_DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (bus1)
    );

    data_mem_lsu #(.MEM_DEPTH(DEPTH), .LATENCY(LAT4)) dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    logic [7:0] mref [int unsigned];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: apply the access rules to a byte-addressed array.
    task automatic model(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] r);
        int unsigned size;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        e = (size == 0) || (we && f3[2]) || (a % size != 0)
            || (a / 4 >= DEPTH);
        r = 32'h0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < int'(size); i++)
                    mref[a + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < int'(size); i++)
                    v = v | (32'(mref[a + i]) << (8 * i));
                if (size == 1 && !f3[2]) v = {{24{v[7]}}, v[7:0]};
                if (size == 2 && !f3[2]) v = {{16{v[15]}}, v[15:0]};
                r = v;
            end
        end
    endtask

    task automatic txn(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input string tag,
                       output logic [31:0] rd, output logic er);
        int n;
        logic e_exp;
        logic [31:0] r_exp;
        n = 0;
        while (bus1.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready"}, 32'(bus1.req_ready), 32'd1);
        bus1.req_valid  = 1'b1;
        bus1.req_we     = we;
        bus1.req_funct3 = f3;
        bus1.req_addr   = a;
        bus1.req_wdata  = wd;
        @(posedge clk);
        #1 bus1.req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus1.rsp_valid !== 1'b1 && n < 20);
        chk({tag, " lat"}, 32'(n), 32'(LAT1 + 1));
        model(we, f3, a, wd, e_exp, r_exp);
        chk({tag, " err"}, 32'(bus1.rsp_err), 32'(e_exp));
        chk({tag, " rdata"}, bus1.rsp_rdata, r_exp);
        chk({tag, " busy"}, 32'(bus1.req_ready), 32'd0);
        rd = bus1.rsp_rdata;
        er = bus1.rsp_err;
        @(negedge clk);
        chk({tag, " pulse"}, 32'(bus1.rsp_valid), 32'd0);
        chk({tag, " ready2"}, 32'(bus1.req_ready), 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    logic [2:0]  f3;
    logic [31:0] a;
    logic        we;

    initial begin
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = 3'd0;
        bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0;
        bus4.req_valid = 1'b0; bus4.req_we = 1'b0; bus4.req_funct3 = 3'd0;
        bus4.req_addr = 32'h0; bus4.req_wdata = 32'h0;
        rst1_n = 1'b0;
        rst4_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst ready", 32'(bus1.req_ready), 32'd1);
        chk("rst valid", 32'(bus1.rsp_valid), 32'd0);
        chk("rst rdata", bus1.rsp_rdata, 32'h0);
        chk("rst err", 32'(bus1.rsp_err), 32'd0);
        rst1_n = 1'b1;
        rst4_n = 1'b1;
        @(negedge clk);

        txn(1, 3'b010, 32'h10, 32'hDEADBEEF, "sw", rd, er);
        chk("sw rd0", rd, 32'h0);
        chk("sw ok", 32'(er), 32'd0);
        txn(0, 3'b000, 32'h11, 32'h0, "lb", rd, er);
        chk("lb", rd, 32'hFFFFFFBE);
        txn(0, 3'b100, 32'h11, 32'h0, "lbu", rd, er);
        chk("lbu", rd, 32'h000000BE);
        txn(0, 3'b001, 32'h12, 32'h0, "lh", rd, er);
        chk("lh", rd, 32'hFFFFDEAD);
        txn(0, 3'b101, 32'h10, 32'h0, "lhu", rd, er);
        chk("lhu", rd, 32'h0000BEEF);
        txn(0, 3'b010, 32'h10, 32'h0, "lw", rd, er);
        chk("lw", rd, 32'hDEADBEEF);

        txn(1, 3'b000, 32'h13, 32'h00000012, "sb", rd, er);
        txn(0, 3'b010, 32'h10, 32'h0, "lw sb", rd, er);
        chk("lw sb", rd, 32'h12ADBEEF);
        txn(1, 3'b001, 32'h10, 32'h00005555, "sh", rd, er);
        txn(0, 3'b010, 32'h10, 32'h0, "lw sh", rd, er);
        chk("lw sh", rd, 32'h12AD5555);

        txn(0, 3'b010, 32'h12, 32'h0, "lw mis", rd, er);
        chk("lw mis err", 32'(er), 32'd1);
        chk("lw mis rd", rd, 32'h0);
        txn(1, 3'b001, 32'h11, 32'h0000AAAA, "sh mis", rd, er);
        chk("sh mis err", 32'(er), 32'd1);
        txn(0, 3'b010, 32'h10, 32'h0, "lw keep", rd, er);
        chk("lw keep", rd, 32'h12AD5555);
        txn(0, 3'b010, 32'(4 * DEPTH), 32'h0, "lw oor", rd, er);
        chk("lw oor err", 32'(er), 32'd1);
        txn(0, 3'b011, 32'h10, 32'h0, "f3 011", rd, er);
        chk("f3 011 err", 32'(er), 32'd1);
        txn(1, 3'b100, 32'h10, 32'h0, "sbu", rd, er);
        chk("sbu err", 32'(er), 32'd1);

        // Abort a store with reset while it waits for its access edge.
        txn(1, 3'b010, 32'h20, 32'h11111111, "sw pre", rd, er);
        bus1.req_valid  = 1'b1;
        bus1.req_we     = 1'b1;
        bus1.req_funct3 = 3'b010;
        bus1.req_addr   = 32'h20;
        bus1.req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        #2 bus1.req_valid = 1'b0;
        rst1_n = 1'b0;
        #1;
        chk("abort ready", 32'(bus1.req_ready), 32'd1);
        chk("abort valid", 32'(bus1.rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst1_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort norsp", 32'(bus1.rsp_valid), 32'd0);
        end
        txn(0, 3'b010, 32'h20, 32'h0, "lw abort", rd, er);
        chk("lw abort", 32'(rd == 32'hCAFEF00D), 32'd0);

        for (int i = 0; i < 16; i++)
            txn(1, 3'b010, 32'(4 * i), $urandom, "init", rd, er);
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            if ($urandom_range(0, 7) == 0)
                a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
            else
                a = 32'($urandom_range(0, 63));
            txn(we, f3, a, $urandom, "rnd", rd, er);
        end

        // Slow instance with a request held valid throughout.
        @(negedge clk);
        bus4.req_valid  = 1'b1;
        bus4.req_we     = 1'b1;
        bus4.req_funct3 = 3'b010;
        bus4.req_addr   = 32'h0;
        bus4.req_wdata  = 32'h0;
        for (int i = 0; i < 3 * (LAT4 + 2); i++) begin
            chk("l4 ready", 32'(bus4.req_ready),
                32'(i % (LAT4 + 2) == 0));
            chk("l4 rsp", 32'(bus4.rsp_valid),
                32'(i % (LAT4 + 2) == LAT4 + 1));
            if (i == 3 * (LAT4 + 2) - 1) bus4.req_valid = 1'b0;
            @(negedge clk);
        end
        chk("l4 idle", 32'(bus4.req_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
